// File: rtl/spoken_number_accumulator.sv
// Assembles a decimal number from spoken digit-group word IDs and converts it to BCD.
// Optional macro DIGIT_GROUP_CHECK_EN rejects words that would overwrite an occupied group.
module spoken_number_accumulator #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14,
  parameter int ID_W   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_W-1:0]       id,
  input  logic                  id_valid,
  output logic [VAL_W-1:0]      value_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int DONE_ID  = 28 + 9 * (DIGITS - 2);
  localparam int START_ID = DONE_ID + 1;
  localparam int BCD_W    = 4 * DIGITS;
  localparam int DD_W     = BCD_W + VAL_W;
  localparam int CNT_W    = $clog2(VAL_W + 1);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, COLLECT, CONVERT, PRESENT} state_t;
  state_t state, state_nxt;

  logic [31:0]       id_ext;
  logic [DIGITS-1:0] hit;
  logic [VAL_W-1:0]  gval [DIGITS];
  logic [VAL_W-1:0]  wv   [DIGITS+1];
  logic [VAL_W-1:0]  grp  [DIGITS];
  logic [VAL_W-1:0]  psum [DIGITS+1];
  logic [VAL_W-1:0]  word_val;
  logic              is_num, is_done, is_start, is_bad, is_teen;
  logic              acc, reject, grp_clr, grp_wr, load;

  logic [VAL_W-1:0]  sum_p0;
  logic [DD_W-1:0]   dd_p0;
  logic [DD_W-1:0]   dd_adj;
  logic [CNT_W-1:0]  cnt_p0;

  assign id_ext = 32'(id);

  // Word decode: each digit position owns a contiguous ID range
  assign wv[0]   = '0;
  assign psum[0] = '0;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_ones
      assign hit[g]  = (id_ext >= 32'd1) && (id_ext <= 32'd9);
      assign gval[g] = VAL_W'(id_ext);
    end else if (g == 1) begin : g_tens
      assign hit[g]  = (id_ext >= 32'd10) && (id_ext <= 32'd27);
      assign gval[g] = (id_ext <= 32'd20) ? VAL_W'(id_ext)
                                          : VAL_W'((id_ext - 32'd18) * 32'd10);
    end else begin : g_high
      localparam int BASE = 28 + 9 * (g - 2);
      localparam int POW  = pow10(g);
      assign hit[g]  = (id_ext >= 32'(BASE)) && (id_ext <= 32'(BASE + 8));
      assign gval[g] = VAL_W'((id_ext - 32'(BASE) + 32'd1) * 32'(POW));
    end
    assign wv[g+1]   = wv[g] | (hit[g] ? gval[g] : '0);
    assign psum[g+1] = psum[g] + grp[g];
  end

  assign word_val = wv[DIGITS];
  assign is_num   = |hit;
  assign is_done  = (id_ext == 32'(DONE_ID));
  assign is_start = (id_ext == 32'(START_ID));
  assign is_bad   = !is_num && !is_done && !is_start;
  assign is_teen  = (id_ext >= 32'd10) && (id_ext <= 32'd19);

  assign acc     = id_valid && ((state == IDLE) || (state == COLLECT));
  assign grp_clr = acc && (is_start || ((state == IDLE) && is_num));
  assign grp_wr  = acc && is_num && !reject;
  assign load    = acc && (state == COLLECT) && is_done;

`ifdef DIGIT_GROUP_CHECK_EN
  logic [DIGITS:0] occ;
  logic            tens_teen;
  assign occ[0] = 1'b0;
  for (genvar g = 0; g < DIGITS; g++) begin : g_occ
    assign occ[g+1] = occ[g] | (hit[g] && (grp[g] != '0));
  end
  assign tens_teen = (grp[1] >= VAL_W'(10)) && (grp[1] <= VAL_W'(19));
  assign reject    = (state == COLLECT) &&
                     (occ[DIGITS] || (hit[0] && tens_teen) || (is_teen && (grp[0] != '0)));
`else
  assign reject = 1'b0;
`endif

  // Group registers; a teen word also clears the ones group
  for (genvar g = 0; g < DIGITS; g++) begin : g_grp
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        grp[g] <= '0;
      end else if (grp_wr && hit[g]) begin
        grp[g] <= word_val;
      end else if (grp_clr || ((g == 0) && grp_wr && is_teen)) begin
        grp[g] <= '0;
      end
    end
  end

  // Double-dabble step: add 3 to nibbles >= 5, binary part passes through
  assign dd_adj[VAL_W-1:0] = dd_p0[VAL_W-1:0];
  for (genvar g = 0; g < DIGITS; g++) begin : g_dd
    logic [3:0] nib;
    assign nib = dd_p0[VAL_W + 4*g +: 4];
    assign dd_adj[VAL_W + 4*g +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc && (is_start || is_num)) state_nxt = COLLECT;
      COLLECT: if (acc && is_done) state_nxt = CONVERT;
      CONVERT: if (cnt_p0 == CNT_W'(VAL_W)) state_nxt = PRESENT;
      PRESENT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: sum latch, shift-and-adjust, then register results on the way to PRESENT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_p0    <= '0;
      dd_p0     <= '0;
      cnt_p0    <= '0;
      value_out <= '0;
      bcd_out   <= '0;
    end else if (load) begin
      sum_p0 <= psum[DIGITS];
      dd_p0  <= {{BCD_W{1'b0}}, psum[DIGITS]};
      cnt_p0 <= '0;
    end else if (state == CONVERT) begin
      if (cnt_p0 != CNT_W'(VAL_W)) begin
        dd_p0  <= {dd_adj[DD_W-2:0], 1'b0};
        cnt_p0 <= cnt_p0 + 1'b1;
      end else begin
        value_out <= sum_p0;
        bcd_out   <= dd_p0[DD_W-1:VAL_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (acc) begin
      if (is_start)              err <= 1'b0;
      else if (is_bad || reject) err <= 1'b1;
    end
  end

  // The cycle right after DONE is the load slot, so busy starts one edge later
  assign busy      = ((state == CONVERT) && (cnt_p0 != '0)) || (state == PRESENT);
  assign out_valid = (state == PRESENT);

endmodule

// File: tb/tb_spoken_number_accumulator.sv
// Scoreboard bench for spoken_number_accumulator: directed word sequences, monitor-side checking.
module tb_spoken_number_accumulator;

  localparam int DIGITS = 4;
  localparam int VAL_W  = 14;
  localparam int ID_W   = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [ID_W-1:0]   id;
  logic              id_valid;
  logic [VAL_W-1:0]  value_out;
  logic [15:0]       bcd_out;
  logic              out_valid;
  logic              busy;
  logic              err;

  spoken_number_accumulator #(.DIGITS(DIGITS), .VAL_W(VAL_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .id(id), .id_valid(id_valid),
    .value_out(value_out), .bcd_out(bcd_out), .out_valid(out_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VAL_W-1:0] v;
    logic [15:0]      b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a result
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("value_out", 32'(value_out), 32'(e.v));
          check("bcd_out", 32'(bcd_out), 32'(e.b));
        end
      end
    end
  end

  task automatic send(input int w);
    @(negedge clk);
    id = ID_W'(w);
    id_valid = 1'b1;
    @(negedge clk);
    id_valid = 1'b0;
  endtask

  task automatic expect_out(input int v, input logic [15:0] b);
    exp_t e;
    e.v = VAL_W'(v);
    e.b = b;
    q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    id = '0;
    id_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", 32'(value_out), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 4647 with latency measurement
    send(47); send(40); send(33); send(22); send(7);
    expect_out(4647, 16'h4647);
    busy_cnt = 0;
    send(46);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'd15);
    drain();

    // Implicit start with a teen word, then an empty number
    send(15); expect_out(15, 16'h0015); send(46); drain();
    send(47); expect_out(0, 16'h0000); send(46); drain();

    // Invalid ID in COLLECT leaves groups alone, START clears err
    send(47); send(5); send(55);
    check("err_invalid", 32'(err), 32'd1);
    expect_out(5, 16'h0005); send(46); drain();
    check("err_sticky", 32'(err), 32'd1);
    send(47);
    check("err_clear", 32'(err), 32'd0);
    expect_out(0, 16'h0000); send(46); drain();

    // Same-group overwrite behaviour
    send(47); send(3); send(5);
`ifdef DIGIT_GROUP_CHECK_EN
    check("err_group", 32'(err), 32'd1);
    expect_out(3, 16'h0003);
`else
    check("err_group", 32'(err), 32'd0);
    expect_out(5, 16'h0005);
`endif
    send(46); drain();

    // Invalid ID in IDLE sets err
    send(0);
    check("err_idle_invalid", 32'(err), 32'd1);

    // Word during CONVERT is dropped; busy length
    send(47); send(2);
    expect_out(2, 16'h0002);
    busy_cnt = 0;
    send(46);
    send(9);
    drain();
    repeat (5) @(negedge clk);
    check("busy_cycles", 32'(busy_cnt), 32'd15);
    check("err_busy_drop", 32'(err), 32'd0);
    send(46);
    repeat (20) @(negedge clk);

    // Reset in the 5th CONVERT cycle aborts without a pulse
    send(47); send(9); send(46);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("abort_value", 32'(value_out), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);

    // 9999 after the abort
    send(47); send(45); send(36); send(27); send(9);
    expect_out(9999, 16'h9999);
    send(46);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
